hero_txn_buffer: RTL and testbench

HERO_TXN_BUFFER -- requirements
Module: hero_txn_buffer

---
 rtl/hero_txn_buffer.sv | 207 ++++++++++++++++++++
 tb/tb_hero_txn_buffer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hero_txn_buffer.sv
`default_nettype none
// ============================================================================
// Module   : hero_txn_buffer
// Purpose  : Store-and-forward transaction buffer for hero write beats.
//            Beats of a transaction are written speculatively; the whole
//            transaction becomes visible at the output only once its DONE
//            beat has been stored. Transactions that overflow the storage
//            or exceed MAX_BEATS are discarded in full.
// Ports    :
//   clk            clock, all state changes on rising edge
//   rst            asynchronous active-high reset
//   in_cycle_type  beat type: 0 IDLE, 1 VALID, 2 DONE, 3 reserved
//   in_wdat        beat data
//   in_clk_en      beat qualifier
//   out_valid      output beat available
//   out_ready      output beat consumed when high with out_valid
//   out_wdat       output beat data
//   out_last       final beat of a transaction
//   overflow_err   sticky: a transaction was dropped for lack of space
//   proto_err      sticky: over-long transaction or reserved beat type
//   err_clr        clears both sticky flags
//   txn_count      committed transactions (statistics build only)
//   drop_count     discarded transactions (statistics build only)
// Config   : define HERO_TXN_BUFFER_STATS_EN to build the statistics
//            counters; otherwise txn_count/drop_count are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module hero_txn_buffer #(
  parameter int DATA_WIDTH = 36,
  parameter int DEPTH      = 8,
  parameter int MAX_BEATS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            in_cycle_type,
  input  logic [DATA_WIDTH-1:0] in_wdat,
  input  logic                  in_clk_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_wdat,
  output logic                  out_last,
  output logic                  overflow_err,
  output logic                  proto_err,
  input  logic                  err_clr,
  output logic [15:0]           txn_count,
  output logic [15:0]           drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DROP   = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   wr_ptr, wr_ptr_nx;   // speculative write pointer
  logic [PW-1:0]   cm_ptr, cm_ptr_nx;   // end of last committed transaction
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   beat_cnt, beat_cnt_nx;

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [DATA_WIDTH:0] rd_entry;

  logic is_valid, is_done, is_rsvd;
  logic full, too_long;
  logic accept_beat, reject;
  logic mem_we, set_ov, set_pe;

  assign is_valid = in_clk_en && (in_cycle_type == 2'd1);
  assign is_done  = in_clk_en && (in_cycle_type == 2'd2);
  assign is_rsvd  = in_clk_en && (in_cycle_type == 2'd3);

  // Full counts uncommitted beats too, and uses the registered rd_ptr, so a
  // read in the same cycle never makes room for the incoming beat.
  assign full     = (wr_ptr - rd_ptr) == PW'(DEPTH);
  assign too_long = (beat_cnt == CW'(MAX_BEATS));

  assign accept_beat = (state != S_DROP) && (is_valid || is_done);
  assign reject      = accept_beat && (full || too_long);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      cm_ptr   <= '0;
      rd_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      wr_ptr   <= wr_ptr_nx;
      cm_ptr   <= cm_ptr_nx;
      beat_cnt <= beat_cnt_nx;
      if (out_valid && out_ready) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    wr_ptr_nx   = wr_ptr;
    cm_ptr_nx   = cm_ptr;
    beat_cnt_nx = beat_cnt;
    mem_we      = 1'b0;
    set_ov      = 1'b0;
    set_pe      = is_rsvd;
    case (state)
      S_IDLE, S_ACTIVE: begin
        if (reject) begin
          // Throw away every beat of this transaction written so far.
          wr_ptr_nx   = cm_ptr;
          beat_cnt_nx = '0;
          if (full) begin
            set_ov = 1'b1;
          end else begin
            set_pe = 1'b1;
          end
          state_nx = is_done ? S_IDLE : S_DROP;
        end else if (accept_beat) begin
          mem_we    = 1'b1;
          wr_ptr_nx = wr_ptr + 1'b1;
          if (is_done) begin
            // Commit lands together with the last write so the output can
            // see the transaction on the very next cycle.
            cm_ptr_nx   = wr_ptr + 1'b1;
            beat_cnt_nx = '0;
            state_nx    = S_IDLE;
          end else begin
            beat_cnt_nx = beat_cnt + 1'b1;
            state_nx    = S_ACTIVE;
          end
        end
      end
      S_DROP: begin
        if (is_done) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr[AW-1:0]] <= {is_done, in_wdat};
    end
  end

  // Entry rd_ptr is never rewritten while it is visible, because the write
  // side stalls on full, so the output stays stable under backpressure.
  assign rd_entry  = mem[rd_ptr[AW-1:0]];
  assign out_valid = (rd_ptr != cm_ptr);
  assign out_wdat  = out_valid ? rd_entry[DATA_WIDTH-1:0] : '0;
  assign out_last  = out_valid & rd_entry[DATA_WIDTH];

  // Set beats clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_err <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      if (set_ov) begin
        overflow_err <= 1'b1;
      end else if (err_clr) begin
        overflow_err <= 1'b0;
      end
      if (set_pe) begin
        proto_err <= 1'b1;
      end else if (err_clr) begin
        proto_err <= 1'b0;
      end
    end
  end

`ifdef HERO_TXN_BUFFER_STATS_EN
  logic commit;
  logic [15:0] txn_q, drop_q;

  assign commit = accept_beat && !reject && is_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_q  <= '0;
      drop_q <= '0;
    end else begin
      if (commit && (txn_q != 16'hFFFF)) begin
        txn_q <= txn_q + 1'b1;
      end
      if (reject && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  assign txn_count  = txn_q;
  assign drop_count = drop_q;
`else
  assign txn_count  = 16'd0;
  assign drop_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hero_txn_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hero_txn_buffer
// Purpose  : Self-checking bench for hero_txn_buffer. Two instances share
//            the stimulus: ua (DEPTH=8) and ub (DEPTH=32), both MAX_BEATS=16.
//            A transaction-level model (queues of committed and partial
//            beats) predicts every output each cycle; literal checks pin
//            the directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hero_txn_buffer;

  localparam int DW   = 36;
  localparam int MAXB = 16;
  localparam int M_IDLE = 0, M_ACT = 1, M_DROP = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    in_cycle_type = 2'd0;
  logic [DW-1:0] in_wdat = '0;
  logic          in_clk_en = 1'b0;
  logic          out_ready = 1'b1;
  logic          err_clr = 1'b0;

  logic [1:0]          o_valid, o_last, o_ov, o_pe;
  logic [1:0][DW-1:0]  o_wdat;
  logic [1:0][15:0]    o_txn, o_drop;

  always #5 clk = ~clk;

  hero_txn_buffer #(.DATA_WIDTH(DW), .DEPTH(8), .MAX_BEATS(MAXB)) ua (
    .clk(clk), .rst(rst), .in_cycle_type(in_cycle_type), .in_wdat(in_wdat),
    .in_clk_en(in_clk_en), .out_valid(o_valid[0]), .out_ready(out_ready),
    .out_wdat(o_wdat[0]), .out_last(o_last[0]), .overflow_err(o_ov[0]),
    .proto_err(o_pe[0]), .err_clr(err_clr), .txn_count(o_txn[0]),
    .drop_count(o_drop[0]));

  hero_txn_buffer #(.DATA_WIDTH(DW), .DEPTH(32), .MAX_BEATS(MAXB)) ub (
    .clk(clk), .rst(rst), .in_cycle_type(in_cycle_type), .in_wdat(in_wdat),
    .in_clk_en(in_clk_en), .out_valid(o_valid[1]), .out_ready(out_ready),
    .out_wdat(o_wdat[1]), .out_last(o_last[1]), .overflow_err(o_ov[1]),
    .proto_err(o_pe[1]), .err_clr(err_clr), .txn_count(o_txn[1]),
    .drop_count(o_drop[1]));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_edge = 0;
  int first_valid[2];

  // ---------------- transaction-level model ----------------
  logic [DW:0] cq [2][$];   // committed beats awaiting output
  logic [DW:0] pq [2][$];   // beats of the transaction in progress
  logic [DW:0] logq [2][$]; // beats actually handed out by each DUT
  int  mode [2];
  bit  m_ov [2], m_pe [2];
  int  m_txn [2], m_drop [2];

  function automatic int depth_of(input int k);
    return (k == 0) ? 8 : 32;
  endfunction

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d] at cycle %0d: got %h, expected %h", name, k, cyc, act, exp);
    end
  endtask

  task automatic model_step(input int k);
    bit full, tl, acc, dn;
    bit set_ov = 1'b0;
    bit set_pe = 1'b0;
    full = (cq[k].size() + pq[k].size()) == depth_of(k);
    if (cq[k].size() != 0 && out_ready) void'(cq[k].pop_front());
    if (in_clk_en && in_cycle_type == 2'd3) set_pe = 1'b1;
    acc = in_clk_en && (in_cycle_type == 2'd1 || in_cycle_type == 2'd2);
    dn  = (in_cycle_type == 2'd2);
    if (acc) begin
      if (mode[k] == M_DROP) begin
        if (dn) mode[k] = M_IDLE;
      end else begin
        tl = (pq[k].size() == MAXB);
        if (full || tl) begin
          if (full) set_ov = 1'b1; else set_pe = 1'b1;
          pq[k].delete();
`ifdef HERO_TXN_BUFFER_STATS_EN
          if (m_drop[k] < 65535) m_drop[k]++;
`endif
          mode[k] = dn ? M_IDLE : M_DROP;
        end else begin
          pq[k].push_back({dn, in_wdat});
          if (dn) begin
            while (pq[k].size() > 0) cq[k].push_back(pq[k].pop_front());
`ifdef HERO_TXN_BUFFER_STATS_EN
            if (m_txn[k] < 65535) m_txn[k]++;
`endif
            mode[k] = M_IDLE;
          end else begin
            mode[k] = M_ACT;
          end
        end
      end
    end
    if (set_ov) m_ov[k] = 1'b1; else if (err_clr) m_ov[k] = 1'b0;
    if (set_pe) m_pe[k] = 1'b1; else if (err_clr) m_pe[k] = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        cq[k].delete(); pq[k].delete();
        mode[k] = M_IDLE; m_ov[k] = 1'b0; m_pe[k] = 1'b0;
        m_txn[k] = 0; m_drop[k] = 0;
      end else begin
        model_step(k);
      end
    end
  end

  // Compare on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("out_valid", k, 64'(o_valid[k]), 64'(cq[k].size() != 0));
      if (cq[k].size() != 0) begin
        chk("out_wdat", k, 64'(o_wdat[k]), 64'(cq[k][0][DW-1:0]));
        chk("out_last", k, 64'(o_last[k]), 64'(cq[k][0][DW]));
      end
      chk("overflow_err", k, 64'(o_ov[k]), 64'(m_ov[k]));
      chk("proto_err", k, 64'(o_pe[k]), 64'(m_pe[k]));
      chk("txn_count", k, 64'(o_txn[k]), 64'(m_txn[k]));
      chk("drop_count", k, 64'(o_drop[k]), 64'(m_drop[k]));
      if (o_valid[k] && first_valid[k] < 0) first_valid[k] = cyc;
      if (o_valid[k] && out_ready) logq[k].push_back({o_last[k], o_wdat[k]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic beat(input logic [1:0] t, input logic [DW-1:0] d, input logic en);
    in_cycle_type = t; in_wdat = d; in_clk_en = en;
    @(posedge clk); #1;
    last_edge = cyc;
    in_cycle_type = 2'd0; in_clk_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_logs();
    for (int k = 0; k < 2; k++) begin
      logq[k].delete(); first_valid[k] = -1;
    end
  endtask

  task automatic chk_log(input string name, input int k, input int idx, input logic [DW:0] exp);
    logic [DW:0] act;
    act = (idx < logq[k].size()) ? logq[k][idx] : {1'b1, {DW{1'b1}}};
    chk(name, k, 64'(act), 64'(exp));
  endtask

  localparam logic [DW-1:0] A0 = 36'h0A0A0A0A0, A1 = 36'h0A1A1A1A1, A2 = 36'h0A2A2A2A2;
  localparam logic [DW-1:0] B0 = 36'h0B0000000, B1 = 36'h0B1111111, B2 = 36'h0B2222222;

  initial begin
    rst = 1'b1;
    clear_logs();
    idle(2);
    @(negedge clk); #1;
    chk("reset out_valid", 0, 64'(o_valid[0]), 64'd0);
    chk("reset out_wdat", 0, 64'(o_wdat[0]), 64'd0);
    chk("reset out_last", 0, 64'(o_last[0]), 64'd0);
    chk("reset flags", 0, 64'({o_ov[0], o_pe[0]}), 64'd0);
    chk("reset counts", 0, 64'({o_txn[0], o_drop[0]}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Basic 3-beat transaction with the output always ready.
    clear_logs();
    beat(2'd1, A0, 1'b1);
    beat(2'd1, A1, 1'b1);
    beat(2'd2, A2, 1'b1);
    idle(6);
    chk("latency", 0, 64'(first_valid[0]), 64'(last_edge));
    chk("beats_out", 0, 64'(logq[0].size()), 64'd3);
    chk_log("beat0", 0, 0, {1'b0, A0});
    chk_log("beat1", 0, 1, {1'b0, A1});
    chk_log("beat2", 0, 2, {1'b1, A2});

    // 9-beat transaction into 8 entries with the output stalled.
    clear_logs();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) beat(2'd1, DW'(36'h100 + i), 1'b1);
    beat(2'd2, DW'(36'h108), 1'b1);
    idle(2);
    chk("ovf_set", 0, 64'(o_ov[0]), 64'd1);
    chk("ovf_no_valid", 0, 64'(o_valid[0]), 64'd0);
`ifdef HERO_TXN_BUFFER_STATS_EN
    chk("ovf_drop", 0, 64'(o_drop[0]), 64'd1);
`endif
    beat(2'd1, B0, 1'b1);
    beat(2'd1, B1, 1'b1);
    beat(2'd2, B2, 1'b1);
    idle(1);
    out_ready = 1'b1;
    idle(20);
    chk("after_ovf_n", 0, 64'(logq[0].size()), 64'd3);
    chk_log("after_ovf0", 0, 0, {1'b0, B0});
    chk_log("after_ovf2", 0, 2, {1'b1, B2});

    // Over-long transaction on the deep instance.
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    clear_logs();
    for (int i = 0; i < 17; i++) beat(2'd1, DW'(36'h200 + i), 1'b1);
    beat(2'd2, DW'(36'h211), 1'b1);
    idle(3);
    chk("long_pe", 1, 64'(o_pe[1]), 64'd1);
    chk("long_none", 1, 64'(logq[1].size()), 64'd0);
    beat(2'd2, 36'h0C0C0C0C0, 1'b1);
    idle(3);
    chk_log("single_done", 1, 0, {1'b1, 36'h0C0C0C0C0});

    // Qualifier toggling and gaps, including an ignored DONE and a reserved beat.
    clear_logs();
    beat(2'd1, 36'h0D0, 1'b1);
    beat(2'd1, 36'h0D1, 1'b0);
    beat(2'd0, 36'h0EE, 1'b1);
    beat(2'd1, 36'h0D2, 1'b1);
    beat(2'd3, 36'h0EE, 1'b1);
    beat(2'd2, 36'h0D3, 1'b0);
    beat(2'd2, 36'h0D4, 1'b1);
    idle(4);
    chk("qual_n", 0, 64'(logq[0].size()), 64'd3);
    chk_log("qual0", 0, 0, {1'b0, 36'h0D0});
    chk_log("qual1", 0, 1, {1'b0, 36'h0D2});
    chk_log("qual2", 0, 2, {1'b1, 36'h0D4});
    chk("rsvd_pe", 0, 64'(o_pe[0]), 64'd1);

    // Reset in the middle of a transaction.
    clear_logs();
    beat(2'd1, 36'h0E0, 1'b1);
    beat(2'd1, 36'h0E1, 1'b1);
    rst = 1'b1; idle(1); rst = 1'b0;
    chk("rst_flags", 0, 64'({o_ov[0], o_pe[0], o_ov[1], o_pe[1]}), 64'd0);
    chk("rst_valid", 0, 64'(o_valid), 64'd0);
    beat(2'd2, 36'h0E2, 1'b1);
    idle(3);
    chk("rst_n", 0, 64'(logq[0].size()), 64'd1);
    chk_log("rst_single", 0, 0, {1'b1, 36'h0E2});

    // Clear collides with a fresh overflow: the overflow wins.
    clear_logs();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) beat(2'd1, DW'(36'h300 + i), 1'b1);
    err_clr = 1'b1;
    beat(2'd1, DW'(36'h308), 1'b1);
    err_clr = 1'b0;
    beat(2'd2, DW'(36'h309), 1'b1);
    idle(1);
    chk("clr_vs_ovf", 0, 64'(o_ov[0]), 64'd1);
    out_ready = 1'b1;
    idle(20);
    chk("clr_vs_ovf_none", 0, 64'(logq[0].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
